// File: rtl/sid_write_sequencer.sv
// Timed register-write player for the SID core: queues {delay, addr, data}
// commands and issues each write after its delay, counted in 1MHz clkEn ticks.
module sid_write_sequencer #(
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 16
) (
    input  logic                     clk,
    input  logic                     iRst,
    input  logic                     clkEn,
    input  logic                     iCmdValid,
    output logic                     oCmdReady,
    input  logic [DELAY_W-1:0]       iCmdDelay,
    input  logic [4:0]               iCmdAddr,
    input  logic [7:0]               iCmdData,
    input  logic                     iPause,
    input  logic                     iFlush,
    output logic                     oWE,
    output logic [4:0]               oAddr,
    output logic [7:0]               oDataW,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oBusy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = DELAY_W + 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WRITE
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic [CW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wrPtr;
    logic [AW-1:0]        rdPtr;
    logic [DELAY_W-1:0]   cnt;
    logic [4:0]           holdAddr;
    logic [7:0]           holdData;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 dec;
    logic [CW-1:0]        head;

    assign oCmdReady = (oLevel < LW'(DEPTH));
    assign push      = iCmdValid && oCmdReady && !iFlush;
    assign head      = mem[rdPtr];
    assign oBusy     = (state != ST_IDLE) || (oLevel != '0);

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Flush overrides everything; pause only gates the WAIT state, so IDLE
    // pops and an in-flight WRITE proceed regardless.
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        issue     = 1'b0;
        dec       = 1'b0;
        if (iFlush) begin
            stateNext = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (oLevel != '0) begin
                        pop       = 1'b1;
                        stateNext = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!iPause) begin
                        if (cnt == '0) begin
                            issue     = 1'b1;
                            stateNext = ST_WRITE;
                        end else if (clkEn) begin
                            dec = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (oLevel != '0) begin
                        pop       = 1'b1;
                        stateNext = ST_WAIT;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= {iCmdDelay, iCmdAddr, iCmdData};
        end
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            oLevel   <= '0;
            cnt      <= '0;
            holdAddr <= '0;
            holdData <= '0;
            oWE      <= 1'b0;
            oAddr    <= '0;
            oDataW   <= '0;
        end else if (iFlush) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            oLevel <= '0;
            cnt    <= '0;
            oWE    <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr    <= rdPtr + AW'(1);
                cnt      <= head[CW-1:13];
                holdAddr <= head[12:8];
                holdData <= head[7:0];
            end else if (dec) begin
                cnt <= cnt - DELAY_W'(1);
            end
            case ({push, pop})
                2'b10:   oLevel <= oLevel + LW'(1);
                2'b01:   oLevel <= oLevel - LW'(1);
                default: oLevel <= oLevel;
            endcase
            oWE <= issue;
            if (issue) begin
                oAddr  <= holdAddr;
                oDataW <= holdData;
            end
        end
    end

endmodule
